// File: rtl/pass_entry_if.sv
// Keypad-side strobes and checker-side results of the password entry block.
interface pass_entry_if;
    logic       mode;
    logic       mode_def;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic [1:0] mod3_btn;
    logic       enter_out;
    logic       pass_fail;
    logic       locked;
    logic [1:0] try_cnt;
    logic [2:0] dig_cnt;

    modport master (
        output mode, mode_def, digit_valid, digit, enter, clear,
        input  mod3_btn, enter_out, pass_fail, locked, try_cnt, dig_cnt
    );
    modport slave (
        input  mode, mode_def, digit_valid, digit, enter, clear,
        output mod3_btn, enter_out, pass_fail, locked, try_cnt, dig_cnt
    );
endinterface

// File: rtl/pass_entry.sv
// Password entry FSM: collects BCD digits, compares against DEF_PASS on enter,
// counts consecutive failures and locks out for LOCK_CYC cycles after MAX_TRY.
module pass_entry #(
    parameter int                    DIGITS   = 4,
    parameter logic [DIGITS*4-1:0]   DEF_PASS = 16'h1234,
    parameter int                    MAX_TRY  = 3,
    parameter int                    LOCK_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_all_n,
    pass_entry_if.slave  io
);
    localparam int          BW    = DIGITS * 4;
    localparam int          TW    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [2:0]  DIG_N = 3'(DIGITS);
    localparam logic [1:0]  MAX_T = 2'(MAX_TRY);

    typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;

    // Assert asynchronously, release two clk edges after rst_all_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [2:0]      dig_cnt_q, dig_cnt_d;
    logic [1:0]      try_q, try_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      mod3_q, mod3_d;
    logic            enter_out_q, enter_out_d;
    logic            pass_fail_q, pass_fail_d;
    logic            locked_q, locked_d;
    logic            active, dig_ok, match;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        dig_cnt_d   = dig_cnt_q;
        try_d       = try_q;
        timer_d     = timer_q;
        mod3_d      = mod3_q;
        enter_out_d = 1'b0;
        pass_fail_d = 1'b0;
        active      = !io.mode && io.mode_def;
        dig_ok      = io.digit_valid && (io.digit <= 4'd9);
        match       = (dig_cnt_q == DIG_N) && (buf_q == DEF_PASS);
        unique case (state_q)
            IDLE: if (active) begin
                if (io.clear) begin
                    mod3_d = 2'b00;
                end else if (dig_ok) begin
                    buf_d     = BW'(io.digit);
                    dig_cnt_d = 3'd1;
                    mod3_d    = 2'b00;
                    state_d   = ENTRY;
                end
            end
            ENTRY: begin
                if (!active || io.clear) begin
                    buf_d     = '0;
                    dig_cnt_d = '0;
                    state_d   = IDLE;
                end else if (io.enter) begin
                    // Verdict is registered here so the pulses line up with CHECK.
                    state_d = CHECK;
                    if (match) begin
                        enter_out_d = 1'b1;
                        mod3_d      = 2'b01;
                        try_d       = '0;
                    end else begin
                        pass_fail_d = 1'b1;
                        mod3_d      = 2'b00;
                        if (try_q < MAX_T) try_d = try_q + 2'd1;
                    end
                end else if (dig_ok && dig_cnt_q < DIG_N) begin
                    buf_d     = (buf_q << 4) | BW'(io.digit);
                    dig_cnt_d = dig_cnt_q + 3'd1;
                end
            end
            CHECK: begin
                buf_d     = '0;
                dig_cnt_d = '0;
                if (try_q == MAX_T) begin
                    timer_d = TW'(LOCK_CYC - 1);
                    state_d = LOCKOUT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    try_d   = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        locked_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            dig_cnt_q   <= '0;
            try_q       <= '0;
            timer_q     <= '0;
            mod3_q      <= 2'b00;
            enter_out_q <= 1'b0;
            pass_fail_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            dig_cnt_q   <= dig_cnt_d;
            try_q       <= try_d;
            timer_q     <= timer_d;
            mod3_q      <= mod3_d;
            enter_out_q <= enter_out_d;
            pass_fail_q <= pass_fail_d;
            locked_q    <= locked_d;
        end
    end

    assign io.mod3_btn  = mod3_q;
    assign io.enter_out = enter_out_q;
    assign io.pass_fail = pass_fail_q;
    assign io.locked    = locked_q;
    assign io.try_cnt   = try_q;
    assign io.dig_cnt   = dig_cnt_q;
endmodule
